shift_arbiter: RTL

Sequenced, shared shift resource for the core: arbitrates between two requesters (port 0: execute-stage ALU, port 1: load/store alignment path) for a single 32-bit shift datapath supporting SLL, SRL and SRA. Each accepted request is registered into a one-entry result buffer and returned to the requester that issued it over a valid/ready response channel. Throughput is one shift per cycle while responses drain without stall.

---
 rtl/shift_pkg.sv | 20 ++
 rtl/shift_unit.sv | 21 ++
 rtl/shift_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared types and constants for the shift arbiter slice.
// SHIFT_ARB_RR_EN (in shift_arbiter) selects round-robin instead of fixed-priority grant.
package shift_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SHAMT_W = 5;

  typedef enum logic [1:0] {
    OpSll  = 2'b00,
    OpSrl  = 2'b01,
    OpSra  = 2'b10,
    OpPass = 2'b11
  } shift_op_e;

  typedef enum logic {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/shift_unit.sv
// Combinational 32-bit shifter: SLL, SRL, SRA and pass-through.
module shift_unit
  import shift_pkg::*;
(
  input  logic [DATA_W-1:0]  data,
  input  logic [SHAMT_W-1:0] shamt,
  input  shift_op_e          op,
  output logic [DATA_W-1:0]  result
);

  always_comb begin
    result = data;
    unique case (op)
      OpSll:  result = data << shamt;
      OpSrl:  result = data >> shamt;
      OpSra:  result = $unsigned($signed(data) >>> shamt);
      OpPass: result = data;
    endcase
  end

endmodule

// File: rtl/shift_arbiter.sv
// Two-port arbiter in front of one shared shifter with a one-entry result buffer.
// Define SHIFT_ARB_RR_EN for round-robin grant; otherwise port 0 has fixed priority.
module shift_arbiter #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [DATA_W-1:0]  req_data0,
  input  logic [DATA_W-1:0]  req_data1,
  input  logic [SHAMT_W-1:0] req_shamt0,
  input  logic [SHAMT_W-1:0] req_shamt1,
  input  logic [1:0]         req_op0,
  input  logic [1:0]         req_op1,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic [DATA_W-1:0]  rsp_data,
  output logic               busy
);

  import shift_pkg::*;

  arb_state_e         state_q, state_d;
  logic               owner_q, owner_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [1:0]         gnt;
  logic               drain, can_accept, accept, sel;
  logic [DATA_W-1:0]  sel_data, shift_res;
  logic [SHAMT_W-1:0] sel_shamt;
  shift_op_e          sel_op;

`ifdef SHIFT_ARB_RR_EN
  logic ptr_q, ptr_d;

  // ptr_q names the port that wins when both are valid.
  always_comb begin
    gnt = req_valid;
    if (req_valid == 2'b11) begin
      gnt = ptr_q ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = ~sel;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  always_comb begin
    gnt = {req_valid[1] & ~req_valid[0], req_valid[0]};
  end
`endif

  assign drain      = (state_q == StFull) & rsp_ready[owner_q];
  assign can_accept = (state_q == StEmpty) | drain;
  // Ready is suppressed while reset is held so nothing is accepted across it.
  assign req_ready  = gnt & {2{can_accept & i_reset}};
  assign accept     = |(req_valid & req_ready);
  assign sel        = gnt[1];

  assign sel_data  = sel ? req_data1 : req_data0;
  assign sel_shamt = sel ? req_shamt1 : req_shamt0;
  assign sel_op    = shift_op_e'(sel ? req_op1 : req_op0);

  shift_unit u_shift_unit (
    .data   (sel_data),
    .shamt  (sel_shamt),
    .op     (sel_op),
    .result (shift_res)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    data_d  = data_q;
    if (accept) begin
      state_d = StFull;
      owner_d = sel;
      data_d  = shift_res;
    end else if (drain) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= StEmpty;
      owner_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      data_q  <= data_d;
    end
  end

  assign rsp_valid = (state_q == StFull) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_data  = data_q;
  assign busy      = (state_q == StFull);

endmodule
